// File: rtl/sdf_pkg.sv
// ---------------------------------------------------------------------------
// sdf_pkg
//   Shared types and encodings for the radix-2 single-path delay-feedback
//   (SDF) FFT stage controller.
//   - state_t    : controller phase (FILL, BFLY, DRAIN)
//   - DL_IN_*    : delay-line input mux encodings driven on dl_in_sel
//   - OUT_*      : stage output mux encodings driven on out_sel
// ---------------------------------------------------------------------------
package sdf_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BFLY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] DL_IN_DIN  = 2'd0;
  localparam logic [1:0] DL_IN_DIFF = 2'd1;
  localparam logic [1:0] DL_IN_ZERO = 2'd2;

  localparam logic OUT_SUM   = 1'b0;
  localparam logic OUT_DELAY = 1'b1;

endpackage

// File: rtl/sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// sdf_stage_ctrl
//   Sequencer for one radix-2 SDF FFT stage (SIZE-deep delay line plus a
//   butterfly). Counts accepted input blocks and produces every datapath
//   control for the stage. A frame is SIZE blocks of FILL, SIZE blocks of
//   BFLY, then SIZE free-running DRAIN cycles that empty the delay line.
//
//   Parameters:
//     SIZE      delay-line depth in blocks (power of 2, >= 2)
//     TW_STRIDE twiddle ROM address increment per butterfly block
//     TW_AW     twiddle address width
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     din_valid     input block present
//     din_ready     block accepted when valid (low only in DRAIN)
//     sr_shift_en   delay line shifts this cycle
//     dl_in_sel     delay-line input mux (DL_IN_DIN / DL_IN_DIFF / DL_IN_ZERO)
//     bfly_en       butterfly computes this cycle
//     tw_addr       twiddle ROM address for the current butterfly block
//     out_sel       stage output mux (OUT_SUM / OUT_DELAY)
//     dout_valid    registered stage output valid
//     frame_done    registered pulse with the last output block of a frame
//     busy          a frame is in progress
//
//   Optional (macro SDF_STAGE_CTRL_STATUS_EN):
//     frame_cnt     16-bit wrapping count of completed frames
//     err_sticky    set when din_valid is presented while not ready
// ---------------------------------------------------------------------------
module sdf_stage_ctrl
  import sdf_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int TW_STRIDE = 1,
  parameter int TW_AW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sr_shift_en,
  output logic [1:0]       dl_in_sel,
  output logic             bfly_en,
  output logic [TW_AW-1:0] tw_addr,
  output logic             out_sel,
  output logic             dout_valid,
  output logic             frame_done,
  output logic             busy
`ifdef SDF_STAGE_CTRL_STATUS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic             err_sticky
`endif
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_valid_q, dout_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          acc;
  logic          cnt_last;
  logic [TW_AW-1:0] tw_prod;

  assign cnt_last = (cnt_q == CNT_LAST);
  // Product is formed at TW_AW bits so the address wraps naturally.
  assign tw_prod  = TW_AW'(cnt_q) * TW_AW'(TW_STRIDE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_ready   = (state_q != DRAIN);
    acc         = din_valid && (state_q != DRAIN);
    sr_shift_en = 1'b0;
    dl_in_sel   = DL_IN_DIN;
    bfly_en     = 1'b0;
    tw_addr     = '0;
    out_sel     = OUT_SUM;

    case (state_q)
      FILL: begin
        sr_shift_en = acc;
        if (acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = BFLY;
          end
        end
      end
      BFLY: begin
        sr_shift_en = acc;
        bfly_en     = acc;
        dl_in_sel   = DL_IN_DIFF;
        tw_addr     = tw_prod;
        if (acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Free-running: the delay line empties regardless of din_valid.
        sr_shift_en = 1'b1;
        dl_in_sel   = DL_IN_ZERO;
        out_sel     = OUT_DELAY;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase

    // One-cycle delay lines up with the registered butterfly output.
    dout_valid_d = bfly_en || (state_q == DRAIN);
    frame_done_d = (state_q == DRAIN) && cnt_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != FILL) || (cnt_q != '0);

`ifdef SDF_STAGE_CTRL_STATUS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_sticky_q, err_sticky_d;

  always_comb begin
    // Counter steps in the same cycle frame_done is registered high.
    frame_cnt_d  = frame_cnt_q + {15'd0, frame_done_d};
    err_sticky_d = err_sticky_q || (din_valid && !din_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdf_stage_ctrl
//   Self-checking bench for sdf_stage_ctrl with SIZE = 4. The reference
//   model tracks a single position within the 3*SIZE-step frame and derives
//   every output from it; directed phases add literal expectations.
// ---------------------------------------------------------------------------
module tb_sdf_stage_ctrl;

  localparam int SIZE      = 4;
  localparam int TW_STRIDE = 1;
  localparam int TW_AW     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic             sr_shift_en;
  logic [1:0]       dl_in_sel;
  logic             bfly_en;
  logic [TW_AW-1:0] tw_addr;
  logic             out_sel;
  logic             dout_valid;
  logic             frame_done;
  logic             busy;
`ifdef SDF_STAGE_CTRL_STATUS_EN
  logic [15:0]      frame_cnt;
  logic             err_sticky;
`endif

  sdf_stage_ctrl #(
    .SIZE(SIZE), .TW_STRIDE(TW_STRIDE), .TW_AW(TW_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .sr_shift_en(sr_shift_en),
    .dl_in_sel(dl_in_sel),
    .bfly_en(bfly_en),
    .tw_addr(tw_addr),
    .out_sel(out_sel),
    .dout_valid(dout_valid),
    .frame_done(frame_done),
    .busy(busy)
`ifdef SDF_STAGE_CTRL_STATUS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dv_cnt = 0;
  int fd_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // pos: 0..SIZE-1 filling, SIZE..2*SIZE-1 butterfly, 2*SIZE..3*SIZE-1 drain.
  int pos = 0;
  bit prev_dv = 0, prev_fd = 0, merr = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit f, b, d, acc;
      int e_sel, e_tw;
      if (rst) begin
        pos = 0; prev_dv = 0; prev_fd = 0; merr = 0;
      end
      f   = (pos < SIZE);
      b   = (pos >= SIZE) && (pos < 2*SIZE);
      d   = (pos >= 2*SIZE);
      acc = din_valid && !d;
      e_sel = f ? 0 : (b ? 1 : 2);
      e_tw  = b ? (((pos - SIZE) * TW_STRIDE) % (1 << TW_AW)) : 0;

      chk("din_ready",   int'(din_ready),   int'(!d));
      chk("sr_shift_en", int'(sr_shift_en), int'(acc || d));
      chk("dl_in_sel",   int'(dl_in_sel),   e_sel);
      chk("bfly_en",     int'(bfly_en),     int'(acc && b));
      chk("tw_addr",     int'(tw_addr),     e_tw);
      chk("out_sel",     int'(out_sel),     int'(d));
      chk("busy",        int'(busy),        int'(pos != 0));
      chk("dout_valid",  int'(dout_valid),  int'(prev_dv));
      chk("frame_done",  int'(frame_done),  int'(prev_fd));
`ifdef SDF_STAGE_CTRL_STATUS_EN
      chk("err_sticky",  int'(err_sticky),  int'(merr));
`endif
      if (dout_valid) dv_cnt++;
      if (frame_done) fd_cnt++;

      if (!rst) begin
        prev_dv = (acc && b) || d;
        prev_fd = (pos == 3*SIZE - 1);
        if (din_valid && d) merr = 1;
        if (acc || d) pos = (pos + 1) % (3*SIZE);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v);
    din_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    din_valid = 1'b0;
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] pat;
    #2 rst = 1'b1;
    chk_en = 1;
    @(posedge clk); #1;
    do_reset(2);

    // Idle after reset: nothing moves.
    repeat (8) cyc(1'b0);
    chk("idle_dv_total", dv_cnt, 0);
    $display("idle after reset: dout pulses=%0d", dv_cnt);

    // Directed frame: valid for 8 cycles, then idle.
    dv_cnt = 0; fd_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      din_valid = (c < 8);
      @(negedge clk);
      chk("dir_dout_valid", int'(dout_valid), int'(c >= 5 && c <= 12));
      chk("dir_frame_done", int'(frame_done), int'(c == 12));
      chk("dir_din_ready",  int'(din_ready),  int'(!(c >= 8 && c <= 11)));
      if (c >= 4 && c <= 7) chk("dir_tw_addr", int'(tw_addr), c - 4);
      if (c >= 8 && c <= 11) chk("dir_out_sel", int'(out_sel), 1);
      @(posedge clk); #1;
    end
    chk("dir_dv_total", dv_cnt, 8);
    chk("dir_fd_total", fd_cnt, 1);
    $display("directed frame: dout pulses=%0d frame_done=%0d", dv_cnt, fd_cnt);

    // Bubbles in BFLY: pattern 1,0,1,1,0,1.
    repeat (SIZE) cyc(1'b1);
    pat = 6'b101101; // bit 5 first
    for (int i = 0; i < 6; i++) begin
      din_valid = pat[5 - i];
      @(negedge clk);
      case (i)
        1: begin chk("bub_tw_hold1", int'(tw_addr), 1); chk("bub_bfly_off", int'(bfly_en), 0); end
        4: chk("bub_tw_hold3", int'(tw_addr), 3);
        5: chk("bub_bfly_last", int'(bfly_en), 1);
        default: ;
      endcase
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    @(negedge clk);
    chk("bub_drain_ready", int'(din_ready), 0);
    @(posedge clk); #1;
    repeat (2*SIZE) cyc(1'b0);
    $display("bubble frame done, busy=%0d", busy);

    // Mid-frame reset with cnt = 2 in BFLY.
    repeat (SIZE + 2) cyc(1'b1);
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_dout_valid", int'(dout_valid), 0);
    chk("mrst_busy",       int'(busy),       0);
    chk("mrst_tw_addr",    int'(tw_addr),    0);
    chk("mrst_din_ready",  int'(din_ready),  1);
    @(posedge clk); #1;
    rst = 1'b0;
    din_valid = 1'b1;
    @(negedge clk);
    chk("mrst_fill_sel", int'(dl_in_sel), 0);
    chk("mrst_fill_bfly", int'(bfly_en), 0);
    @(posedge clk); #1;
    $display("mid-frame reset: restarted in fill");

    // Back-to-back: continuous valid for 3 frames (also drives into DRAIN).
    do_reset(1);
    dv_cnt = 0; fd_cnt = 0;
    repeat (3*3*SIZE) cyc(1'b1);
    repeat (3) cyc(1'b0);
    chk("b2b_dv_total", dv_cnt, 6*SIZE);
    chk("b2b_fd_total", fd_cnt, 3);
`ifdef SDF_STAGE_CTRL_STATUS_EN
    chk("b2b_frame_cnt",  int'(frame_cnt),  3);
    chk("b2b_err_sticky", int'(err_sticky), 1);
`endif
    $display("back-to-back: dout pulses=%0d frame_done=%0d", dv_cnt, fd_cnt);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      int p;
      p = (i / 250) % 2 == 0 ? 80 : 35;
      if ($urandom_range(0, 299) == 0) begin
        din_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        cyc(logic'($urandom_range(0, 99) < p));
      end
    end
    repeat (3*SIZE) cyc(1'b0);
    $display("random traffic: 1500 cycles");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
